// File: rtl/skull_sprite_mover_pkg.sv
// Shared constants, types and the per-axis bounce helper for the skull sprite mover.
package skull_sprite_mover_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int RGB_W    = 8;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = rgb_t'(24'h000000);

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // One frame of motion on one axis; 11-bit sums keep pos+step from wrapping.
    function automatic axis_t axis_step(input axis_t cur, input logic [10:0] step,
                                        input logic [10:0] lim);
        axis_t      res;
        logic [10:0] p;
        res = cur;
        p   = {1'b0, cur.pos};
        if (cur.dir == DIR_POS) begin
            if (p + step >= lim) begin
                res.pos = 10'(lim);
                res.dir = DIR_NEG;
            end else begin
                res.pos = 10'(p + step);
            end
        end else begin
            if (p <= step) begin
                res.pos = 10'd0;
                res.dir = DIR_POS;
            end else begin
                res.pos = 10'(p - step);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/skull_sprite_mover_if.sv
// Video timing, background, sprite ROM and composited-colour bundle of the skull sprite mover.
interface skull_sprite_mover_if;
    import skull_sprite_mover_pkg::*;

    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic             video_on;
    logic             frame_tick;
    logic             enable;
    logic [RGB_W-1:0] bg_R;
    logic [RGB_W-1:0] bg_G;
    logic [RGB_W-1:0] bg_B;
    logic [9:0]       spr_x;
    logic [9:0]       spr_y;
    logic [RGB_W-1:0] spr_R;
    logic [RGB_W-1:0] spr_G;
    logic [RGB_W-1:0] spr_B;
    logic             spr_A;
    logic [RGB_W-1:0] R;
    logic [RGB_W-1:0] G;
    logic [RGB_W-1:0] B;
    logic [9:0]       pos_x;
    logic [9:0]       pos_y;

    modport master (
        output hcount, vcount, video_on, frame_tick, enable, bg_R, bg_G, bg_B,
               spr_R, spr_G, spr_B, spr_A,
        input  spr_x, spr_y, R, G, B, pos_x, pos_y
    );

    modport slave (
        input  hcount, vcount, video_on, frame_tick, enable, bg_R, bg_G, bg_B,
               spr_R, spr_G, spr_B, spr_A,
        output spr_x, spr_y, R, G, B, pos_x, pos_y
    );
endinterface

// File: rtl/skull_sprite_mover_sprite_motion.sv
// Per-frame bouncing position of the sprite's top-left corner, clamped to the visible area.
module sprite_motion
    import skull_sprite_mover_pkg::*;
#(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int STEP   = 2,
    parameter int INIT_X = 100,
    parameter int INIT_Y = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enable,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    localparam logic [10:0] XMAX_C = 11'(SCREEN_W - SPR_W);
    localparam logic [10:0] YMAX_C = 11'(SCREEN_H - SPR_H);
    localparam logic [10:0] STEP_C = 11'(STEP);

    axis_t x_r;
    axis_t y_r;
    axis_t x_nxt_s;
    axis_t y_nxt_s;

    // Candidate next position for both axes, evaluated from the pre-tick values.
    always_comb begin
        x_nxt_s = axis_step(x_r, STEP_C, XMAX_C);
        y_nxt_s = axis_step(y_r, STEP_C, YMAX_C);
    end

    // Position/direction register; moves only on an enabled frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= '{pos: 10'(INIT_X), dir: DIR_POS};
            y_r <= '{pos: 10'(INIT_Y), dir: DIR_POS};
        end else if (frame_tick && enable) begin
            x_r <= x_nxt_s;
            y_r <= y_nxt_s;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign pos_x = x_r.pos;
    assign pos_y = y_r.pos;

endmodule

// File: rtl/skull_sprite_mover.sv
// Skull sprite placement: hit test, ROM addressing and two-stage alpha compositing over background.
module skull_sprite_mover
    import skull_sprite_mover_pkg::*;
#(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int STEP   = 2,
    parameter int INIT_X = 100,
    parameter int INIT_Y = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    skull_sprite_mover_if.slave  bus
);

    localparam logic [10:0] SPR_W_C = 11'(SPR_W);
    localparam logic [10:0] SPR_H_C = 11'(SPR_H);

    logic [9:0]  pos_x_s;
    logic [9:0]  pos_y_s;
    logic [10:0] hc_s;
    logic [10:0] vc_s;
    logic [10:0] px_s;
    logic [10:0] py_s;
    logic [9:0]  lx_s;
    logic [9:0]  ly_s;
    logic        in_box_s;
    rgb_t        pix_s;

    logic        in_box_r;
    logic        video_on_r;
    rgb_t        bg_r;
    logic [9:0]  spr_x_r;
    logic [9:0]  spr_y_r;
    rgb_t        pix_r;

    sprite_motion #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .STEP  (STEP),
        .INIT_X(INIT_X),
        .INIT_Y(INIT_Y)
    ) u_motion (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(bus.frame_tick),
        .enable    (bus.enable),
        .pos_x     (pos_x_s),
        .pos_y     (pos_y_s)
    );

    // Hit test against the current box; compares widened so pos+size cannot wrap.
    always_comb begin
        hc_s     = {1'b0, bus.hcount};
        vc_s     = {1'b0, bus.vcount};
        px_s     = {1'b0, pos_x_s};
        py_s     = {1'b0, pos_y_s};
        lx_s     = bus.hcount - pos_x_s;
        ly_s     = bus.vcount - pos_y_s;
        in_box_s = bus.video_on && (hc_s >= px_s) && (hc_s < px_s + SPR_W_C)
                                && (vc_s >= py_s) && (vc_s < py_s + SPR_H_C);
    end

    // Stage 1: ROM address plus the background and flags that travel with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_box_r   <= 1'b0;
            video_on_r <= 1'b0;
            bg_r       <= RGB_BLACK;
            spr_x_r    <= 10'd0;
            spr_y_r    <= 10'd0;
        end else begin
            in_box_r   <= in_box_s;
            video_on_r <= bus.video_on;
            bg_r       <= '{r: bus.bg_R, g: bus.bg_G, b: bus.bg_B};
            spr_x_r    <= in_box_s ? lx_s : 10'd0;
            spr_y_r    <= in_box_s ? ly_s : 10'd0;
        end
    end

    // Composite: blank outside video, opaque sprite texels win, else background.
    always_comb begin
        pix_s = RGB_BLACK;
        if (!video_on_r) begin
            pix_s = RGB_BLACK;
        end else if (in_box_r && bus.spr_A) begin
            pix_s = '{r: bus.spr_R, g: bus.spr_G, b: bus.spr_B};
        end else begin
            pix_s = bg_r;
        end
    end

    // Stage 2: registered colour for the VGA output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_r <= RGB_BLACK;
        end else begin
            pix_r <= pix_s;
        end
    end

    assign bus.spr_x = spr_x_r;
    assign bus.spr_y = spr_y_r;
    assign bus.R     = pix_r.r;
    assign bus.G     = pix_r.g;
    assign bus.B     = pix_r.b;
    assign bus.pos_x = pos_x_s;
    assign bus.pos_y = pos_y_s;

endmodule

// File: tb/tb_skull_sprite_mover.sv
// Randomized self-checking bench for skull_sprite_mover against a behavioural position/pixel model.
module tb_skull_sprite_mover;

    localparam int XMAX = 608;
    localparam int YMAX = 448;
    localparam int STEP = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // behavioural model state
    int mx, my, dx, dy;

    // ROM model control
    logic        rom_mode;
    logic        rom_a;
    logic [24:0] rom_word;

    skull_sprite_mover_if bus();

    skull_sprite_mover dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] rom_pix(input int x, input int y, input logic mode,
                                            input logic a);
        logic [7:0] r, g, b;
        logic       al;
        if (mode) return {a, 24'hBFBFBF};
        r  = 8'((x % 32) * 8 + 5);
        g  = 8'((y % 32) * 8 + 2);
        b  = 8'(x * 7 + y * 3);
        al = ((x % 4) != (y % 4)) ? 1'b1 : 1'b0;
        return {al, r, g, b};
    endfunction

    always_comb rom_word = rom_pix(int'(bus.spr_x), int'(bus.spr_y), rom_mode, rom_a);
    assign bus.spr_A = rom_word[24];
    assign bus.spr_R = rom_word[23:16];
    assign bus.spr_G = rom_word[15:8];
    assign bus.spr_B = rom_word[7:0];

    function automatic logic [23:0] exp_pix(input int h, input int v, input logic von,
                                            input logic [23:0] bg);
        logic [24:0] w;
        if (!von) return 24'h000000;
        if (h >= mx && h < mx + 32 && v >= my && v < my + 32) begin
            w = rom_pix(h - mx, v - my, rom_mode, rom_a);
            if (w[24]) return w[23:0];
        end
        return bg;
    endfunction

    task automatic model_tick();
        int nx, ny;
        nx = mx + dx * STEP;
        ny = my + dy * STEP;
        if (nx >= XMAX) begin mx = XMAX; dx = -1; end
        else if (nx <= 0) begin mx = 0; dx = 1; end
        else mx = nx;
        if (ny >= YMAX) begin my = YMAX; dy = -1; end
        else if (ny <= 0) begin my = 0; dy = 1; end
        else my = ny;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v, input logic von, input logic [23:0] bg);
        bus.hcount   = 10'(h);
        bus.vcount   = 10'(v);
        bus.video_on = von;
        bus.bg_R     = bg[23:16];
        bus.bg_G     = bg[15:8];
        bus.bg_B     = bg[7:0];
    endtask

    task automatic do_reset();
        bus.frame_tick = 1'b0;
        set_pix(0, 0, 1'b0, 24'h0);
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        mx = 100; my = 50; dx = 1; dy = 1;
    endtask

    task automatic do_tick(input logic en);
        bus.frame_tick = 1'b1;
        bus.enable     = en;
        edge1();
        bus.frame_tick = 1'b0;
        if (en) model_tick();
    endtask

    task automatic test_reset();
        set_pix(120, 60, 1'b1, 24'h123456);
        bus.frame_tick = 1'b1;
        bus.enable     = 1'b1;
        rst = 1'b1;
        edge1();
        edge1();
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        mx = 100; my = 50; dx = 1; dy = 1;
        n_tests++;
        if (bus.pos_x !== 10'd100 || bus.pos_y !== 10'd50) begin
            n_fail++;
            $display("FAIL reset_pos: got (%0d,%0d) want (100,50)", bus.pos_x, bus.pos_y);
        end
        n_tests++;
        if ({bus.R, bus.G, bus.B} !== 24'h0 || bus.spr_x !== 10'd0 || bus.spr_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_out: got rgb=%h spr=(%0d,%0d) want 0", {bus.R, bus.G, bus.B},
                     bus.spr_x, bus.spr_y);
        end
    endtask

    task automatic test_motion();
        do_reset();
        do_tick(1'b1);
        n_tests++;
        if (bus.pos_x !== 10'd102 || bus.pos_y !== 10'd52) begin
            n_fail++;
            $display("FAIL first_tick: got (%0d,%0d) want (102,52)", bus.pos_x, bus.pos_y);
        end
        do_tick(1'b0);
        n_tests++;
        if (bus.pos_x !== 10'd102 || bus.pos_y !== 10'd52) begin
            n_fail++;
            $display("FAIL frozen_tick: got (%0d,%0d) want (102,52)", bus.pos_x, bus.pos_y);
        end
        for (int i = 0; i < 60; i++) begin
            do_tick(1'($urandom_range(0, 1)));
            n_tests++;
            if (bus.pos_x !== 10'(mx) || bus.pos_y !== 10'(my)) begin
                n_fail++;
                $display("FAIL rand_enable: got (%0d,%0d) want (%0d,%0d)", bus.pos_x,
                         bus.pos_y, mx, my);
            end
        end
    endtask

    task automatic test_bounce();
        int guard;
        do_reset();
        guard = 0;
        while (bus.pos_x !== 10'd606 && guard < 400) begin do_tick(1'b1); guard++; end
        n_tests++;
        if (guard >= 400) begin
            n_fail++;
            $display("FAIL bounce_reach606: got %0d want 606 within 400 ticks", bus.pos_x);
        end
        do_tick(1'b1);
        n_tests++;
        if (bus.pos_x !== 10'd608) begin
            n_fail++;
            $display("FAIL right_clamp: got %0d want 608", bus.pos_x);
        end
        do_tick(1'b1);
        n_tests++;
        if (bus.pos_x !== 10'd606) begin
            n_fail++;
            $display("FAIL right_reverse: got %0d want 606", bus.pos_x);
        end
        guard = 0;
        while (bus.pos_x !== 10'd2 && guard < 400) begin do_tick(1'b1); guard++; end
        n_tests++;
        if (guard >= 400) begin
            n_fail++;
            $display("FAIL bounce_reach2: got %0d want 2 within 400 ticks", bus.pos_x);
        end
        do_tick(1'b1);
        n_tests++;
        if (bus.pos_x !== 10'd0) begin
            n_fail++;
            $display("FAIL left_clamp: got %0d want 0", bus.pos_x);
        end
        do_tick(1'b1);
        n_tests++;
        if (bus.pos_x !== 10'd2) begin
            n_fail++;
            $display("FAIL left_reverse: got %0d want 2", bus.pos_x);
        end
    endtask

    task automatic test_hit();
        do_reset();
        rom_mode = 1'b0;
        set_pix(100, 50, 1'b1, 24'h010203);
        edge1();
        n_tests++;
        if (bus.spr_x !== 10'd0 || bus.spr_y !== 10'd0) begin
            n_fail++;
            $display("FAIL hit_corner: got (%0d,%0d) want (0,0)", bus.spr_x, bus.spr_y);
        end
        set_pix(131, 81, 1'b1, 24'h040506);
        edge1();
        n_tests++;
        if (bus.spr_x !== 10'd31 || bus.spr_y !== 10'd31) begin
            n_fail++;
            $display("FAIL hit_far: got (%0d,%0d) want (31,31)", bus.spr_x, bus.spr_y);
        end
        set_pix(132, 81, 1'b1, 24'hA5B6C7);
        edge1();
        n_tests++;
        if (bus.spr_x !== 10'd0 || bus.spr_y !== 10'd0) begin
            n_fail++;
            $display("FAIL hit_outside: got (%0d,%0d) want (0,0)", bus.spr_x, bus.spr_y);
        end
        edge1();
        n_tests++;
        if ({bus.R, bus.G, bus.B} !== 24'hA5B6C7) begin
            n_fail++;
            $display("FAIL outside_bg: got %h want a5b6c7", {bus.R, bus.G, bus.B});
        end
    endtask

    task automatic test_alpha();
        logic [23:0] want [3];
        do_reset();
        rom_mode = 1'b1;
        want[0] = 24'hBFBFBF; want[1] = 24'h102030; want[2] = 24'h000000;
        for (int k = 0; k < 3; k++) begin
            rom_a = (k == 0) ? 1'b1 : 1'b0;
            set_pix(110, 60, (k == 2) ? 1'b0 : 1'b1, 24'h102030);
            edge1();
            edge1();
            n_tests++;
            if ({bus.R, bus.G, bus.B} !== want[k]) begin
                n_fail++;
                $display("FAIL alpha_case%0d: got %h want %h", k, {bus.R, bus.G, bus.B},
                         want[k]);
            end
        end
        rom_mode = 1'b0;
    endtask

    task automatic rand_pixel(output logic [23:0] e);
        int h, v;
        logic von;
        logic [23:0] bg;
        h   = mx - 4 + int'($urandom_range(0, 40));
        v   = my - 4 + int'($urandom_range(0, 40));
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        von = ($urandom_range(0, 7) != 0);
        bg  = 24'($urandom);
        set_pix(h, v, von, bg);
        e = exp_pix(h, v, von, bg);
    endtask

    task automatic test_random_pixels();
        logic [23:0] e_prev, e_cur;
        do_reset();
        for (int t = 0; t < 30; t++) do_tick(1'b1);
        rom_mode = 1'b0;
        e_prev = 24'h0;
        for (int i = 0; i < 400; i++) begin
            rand_pixel(e_cur);
            edge1();
            if (i >= 1) begin
                n_tests++;
                if ({bus.R, bus.G, bus.B} !== e_prev) begin
                    n_fail++;
                    $display("FAIL rand_pix[%0d]: got %h want %h", i, {bus.R, bus.G, bus.B},
                             e_prev);
                end
            end
            e_prev = e_cur;
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] ea, eb, ex;
        do_reset();
        for (int t = 0; t < 20; t++) do_tick(1'b1);
        for (int i = 0; i < 10; i++) begin rand_pixel(ex); edge1(); end
        rand_pixel(ex);
        bus.frame_tick = 1'b1;
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        mx = 100; my = 50; dx = 1; dy = 1;
        n_tests++;
        if (bus.pos_x !== 10'd100 || bus.pos_y !== 10'd50 || {bus.R, bus.G, bus.B} !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset: got pos=(%0d,%0d) rgb=%h want (100,50) 000000",
                     bus.pos_x, bus.pos_y, {bus.R, bus.G, bus.B});
        end
        rand_pixel(ea);
        edge1();
        n_tests++;
        if ({bus.R, bus.G, bus.B} !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset_black: got %h want 000000", {bus.R, bus.G, bus.B});
        end
        rand_pixel(eb);
        edge1();
        n_tests++;
        if ({bus.R, bus.G, bus.B} !== ea) begin
            n_fail++;
            $display("FAIL resume_a: got %h want %h", {bus.R, bus.G, bus.B}, ea);
        end
        set_pix(0, 0, 1'b0, 24'h0);
        edge1();
        n_tests++;
        if ({bus.R, bus.G, bus.B} !== eb) begin
            n_fail++;
            $display("FAIL resume_b: got %h want %h", {bus.R, bus.G, bus.B}, eb);
        end
        do_tick(1'b1);
        n_tests++;
        if (bus.pos_x !== 10'd102 || bus.pos_y !== 10'd52) begin
            n_fail++;
            $display("FAIL midreset_dir: got (%0d,%0d) want (102,52)", bus.pos_x, bus.pos_y);
        end
    endtask

    task automatic test_long_run();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) edge1();
            do_tick(1'b1);
            n_tests++;
            if (bus.pos_x !== 10'(mx) || bus.pos_y !== 10'(my)
                || int'(bus.pos_x) > XMAX || int'(bus.pos_y) > YMAX) begin
                n_fail++;
                $display("FAIL long_run[%0d]: got (%0d,%0d) want (%0d,%0d)", i, bus.pos_x,
                         bus.pos_y, mx, my);
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rom_mode = 1'b0;
        rom_a    = 1'b0;
        bus.enable     = 1'b1;
        bus.frame_tick = 1'b0;
        set_pix(0, 0, 1'b0, 24'h0);
        mx = 100; my = 50; dx = 1; dy = 1;
        test_reset();
        test_motion();
        test_bounce();
        test_hit();
        test_alpha();
        test_random_pixels();
        test_reset_mid();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
